// File: rtl/deb_edge_detect.sv
// Single-bit input conditioner: two-flop synchroniser, debounce FSM that
// accepts a new level after STABLE_CYCLES consistent samples, registered
// rise/fall/glitch pulses and a saturating rising-edge counter.
module deb_edge_detect #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d_i,
  input  logic             clr_i,
  output logic             level_o,
  output logic             rise_o,
  output logic             fall_o,
  output logic             glitch_o,
  output logic [CNT_W-1:0] edge_cnt_o
);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    PEND_HI   = 2'd1,
    STABLE_HI = 2'd2,
    PEND_LO   = 2'd3
  } state_t;

  // Compare target widened by one bit so cnt+1 never wraps before the test.
  localparam logic [16:0]      STABLE_TGT = 17'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic             s1_q, s2_q;
  state_t           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [16:0]      cnt_inc;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             glitch_q, glitch_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;

  assign cnt_inc = {1'b0, cnt_q} + 17'd1;

  // Debounce FSM: next state, debounce count, level and event pulses.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    level_d  = level_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    glitch_d = 1'b0;
    case (state_q)
      STABLE_LO: begin
        if (s2_q) begin
          if (STABLE_CYCLES == 1) begin
            state_d = STABLE_HI;
            level_d = 1'b1;
            rise_d  = 1'b1;
          end else begin
            state_d = PEND_HI;
            cnt_d   = 16'd1;
          end
        end
      end
      PEND_HI: begin
        if (s2_q) begin
          cnt_d = cnt_inc[15:0];
          if (cnt_inc == STABLE_TGT) begin
            state_d = STABLE_HI;
            level_d = 1'b1;
            rise_d  = 1'b1;
          end
        end else begin
          // Reversal while pending: abandon the transition, no accumulation.
          state_d  = STABLE_LO;
          glitch_d = 1'b1;
        end
      end
      STABLE_HI: begin
        if (!s2_q) begin
          if (STABLE_CYCLES == 1) begin
            state_d = STABLE_LO;
            level_d = 1'b0;
            fall_d  = 1'b1;
          end else begin
            state_d = PEND_LO;
            cnt_d   = 16'd1;
          end
        end
      end
      PEND_LO: begin
        if (!s2_q) begin
          cnt_d = cnt_inc[15:0];
          if (cnt_inc == STABLE_TGT) begin
            state_d = STABLE_LO;
            level_d = 1'b0;
            fall_d  = 1'b1;
          end
        end else begin
          state_d  = STABLE_HI;
          glitch_d = 1'b1;
        end
      end
      default: state_d = STABLE_LO;
    endcase
  end

  // Rising-edge counter: clear wins over a simultaneous rise; saturates.
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    if (clr_i) begin
      edge_cnt_d = '0;
    end else if (rise_d && (edge_cnt_q != CNT_MAX)) begin
      edge_cnt_d = edge_cnt_q + CNT_W'(1);
    end
  end

  // State registers, all cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      state_q    <= STABLE_LO;
      cnt_q      <= '0;
      level_q    <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      glitch_q   <= 1'b0;
      edge_cnt_q <= '0;
    end else begin
      s1_q       <= d_i;
      s2_q       <= s1_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      level_q    <= level_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      glitch_q   <= glitch_d;
      edge_cnt_q <= edge_cnt_d;
    end
  end

  assign level_o    = level_q;
  assign rise_o     = rise_q;
  assign fall_o     = fall_q;
  assign glitch_o   = glitch_q;
  assign edge_cnt_o = edge_cnt_q;

endmodule
